// File: rtl/sample_requester_pkg.sv
// Shared encodings and default widths for the sine reader request path.
// Imported by the reader, the note player and the sample requester.
package sample_requester_pkg;

    localparam int DEF_STEP_W   = 20;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_TIMEOUT  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/sample_requester.sv
// Codec-strobed request side of the sine reader handshake.
// Issues generate_next, captures the reply and flags timeouts/overruns.
module sample_requester
    import sample_requester_pkg::*;
#(
    parameter int STEP_W   = DEF_STEP_W,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                play,
    input  logic [STEP_W-1:0]   note_step,
    input  logic                codec_strobe,
    input  logic                sample_ready,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                generate_next,
    output logic [STEP_W-1:0]   step_size,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_out_valid,
    output logic                timeout_err,
    output logic                overrun_err
);

    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          timer;
    logic [3:0]          timer_nxt;
    logic [STEP_W-1:0]   step_nxt;
    logic [SAMPLE_W-1:0] sample_nxt;
    logic                valid_nxt;
    logic                tmo_nxt;
    logic                ovr_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            timer            <= '0;
            step_size        <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            timeout_err      <= 1'b0;
            overrun_err      <= 1'b0;
        end else begin
            state            <= state_nxt;
            timer            <= timer_nxt;
            step_size        <= step_nxt;
            sample_out       <= sample_nxt;
            sample_out_valid <= valid_nxt;
            timeout_err      <= tmo_nxt;
            overrun_err      <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        step_nxt   = step_size;
        sample_nxt = sample_out;
        valid_nxt  = 1'b0;
        tmo_nxt    = timeout_err;
        // Strobes during an in-flight request are dropped, not queued.
        ovr_nxt    = overrun_err | (codec_strobe && state != IDLE);
        unique case (state)
            IDLE: begin
                if (codec_strobe) begin
                    if (play) begin
                        step_nxt  = note_step;
                        state_nxt = REQ;
                    end else begin
                        sample_nxt = '0;
                        valid_nxt  = 1'b1;
                    end
                end
            end
            REQ: begin
                timer_nxt = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (sample_ready) begin
                    sample_nxt = sample_in;
                    valid_nxt  = 1'b1;
                    state_nxt  = IDLE;
                end else if (timer == TMO_LAST) begin
                    // Codec still gets a (stale) sample on timeout.
                    tmo_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign generate_next = (state == REQ);

endmodule

// File: tb/tb_sample_requester.sv
// Directed bench for sample_requester with a sample scoreboard.
// Expected samples are queued as stimulus is driven, popped on valid.
module tb_sample_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [19:0] note_step;
    logic        codec_strobe;
    logic        sample_ready;
    logic [15:0] sample_in;
    logic        generate_next;
    logic [19:0] step_size;
    logic [15:0] sample_out;
    logic        sample_out_valid;
    logic        timeout_err;
    logic        overrun_err;

    int checks   = 0;
    int failures = 0;
    int gen_cnt  = 0;
    int vld_cnt  = 0;
    int g0;
    int v0;
    logic [15:0] sb[$];

    sample_requester dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .note_step        (note_step),
        .codec_strobe     (codec_strobe),
        .sample_ready     (sample_ready),
        .sample_in        (sample_in),
        .generate_next    (generate_next),
        .step_size        (step_size),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .timeout_err      (timeout_err),
        .overrun_err      (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid pulse must match the oldest queued sample.
    always @(negedge clk) begin
        if (generate_next) gen_cnt++;
        if (sample_out_valid) begin
            vld_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $error("FAIL sb_unexpected observed=%h expected=none",
                       sample_out);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                assert (sample_out === e) else begin
                    failures++;
                    $error("FAIL sb_sample observed=%h expected=%h",
                           sample_out, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        play         = 1'b0;
        note_step    = '0;
        codec_strobe = 1'b0;
        sample_ready = 1'b0;
        sample_in    = '0;

        // 1. reset
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_gen", {31'd0, generate_next}, 0);
        chk("rst_step", {12'd0, step_size}, 0);
        chk("rst_sample", {16'd0, sample_out}, 0);
        chk("rst_valid", {31'd0, sample_out_valid}, 0);
        chk("rst_flags", {30'd0, timeout_err, overrun_err}, 0);
        v0 = vld_cnt;
        repeat (10) tick();
        chk("rst_idle_valid", vld_cnt - v0, 0);

        // 2. nominal request
        play = 1'b1;
        note_step = 20'h00400;
        codec_strobe = 1'b1;
        g0 = gen_cnt;
        tick();
        codec_strobe = 1'b0;
        chk("nom_gen_t1", {31'd0, generate_next}, 1);
        chk("nom_step", {12'd0, step_size}, 32'h400);
        tick();
        chk("nom_gen_t2", {31'd0, generate_next}, 0);
        sample_ready = 1'b1;
        sample_in = 16'h1234;
        sb.push_back(16'h1234);
        tick();
        sample_ready = 1'b0;
        chk("nom_valid_t3", {31'd0, sample_out_valid}, 1);
        chk("nom_sample_t3", {16'd0, sample_out}, 32'h1234);
        tick();
        chk("nom_valid_t4", {31'd0, sample_out_valid}, 0);
        chk("nom_gen_cnt", gen_cnt - g0, 1);

        // 3. silence
        play = 1'b0;
        codec_strobe = 1'b1;
        g0 = gen_cnt;
        sb.push_back(16'h0000);
        tick();
        codec_strobe = 1'b0;
        chk("sil_gen", {31'd0, generate_next}, 0);
        chk("sil_valid", {31'd0, sample_out_valid}, 1);
        chk("sil_sample", {16'd0, sample_out}, 0);
        tick();
        chk("sil_valid_off", {31'd0, sample_out_valid}, 0);
        chk("sil_step", {12'd0, step_size}, 32'h400);
        chk("sil_gen_cnt", gen_cnt - g0, 0);

        // load a known sample before the timeout case
        play = 1'b1;
        codec_strobe = 1'b1;
        tick();
        codec_strobe = 1'b0;
        tick();
        sample_ready = 1'b1;
        sample_in = 16'h5A5A;
        sb.push_back(16'h5A5A);
        tick();
        sample_ready = 1'b0;
        sample_in = 16'hDEAD;
        tick();

        // 4. timeout: 4 WAIT cycles, stale sample delivered
        codec_strobe = 1'b1;
        g0 = gen_cnt;
        v0 = vld_cnt;
        tick();
        codec_strobe = 1'b0;
        chk("tmo_gen", {31'd0, generate_next}, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tmo_wait_valid", {31'd0, sample_out_valid}, 0);
        end
        chk("tmo_flag_pre", {31'd0, timeout_err}, 0);
        sb.push_back(16'h5A5A);
        tick();
        chk("tmo_flag", {31'd0, timeout_err}, 1);
        chk("tmo_valid", {31'd0, sample_out_valid}, 1);
        chk("tmo_sample", {16'd0, sample_out}, 32'h5A5A);
        tick();
        chk("tmo_gen_cnt", gen_cnt - g0, 1);
        chk("tmo_vld_cnt", vld_cnt - v0, 1);
        codec_strobe = 1'b1;
        tick();
        codec_strobe = 1'b0;
        tick();
        sample_ready = 1'b1;
        sample_in = 16'h0F0F;
        sb.push_back(16'h0F0F);
        tick();
        sample_ready = 1'b0;
        tick();
        chk("tmo_sticky", {31'd0, timeout_err}, 1);
        chk("tmo_no_ovr", {31'd0, overrun_err}, 0);

        // 5. overrun and step stability
        g0 = gen_cnt;
        v0 = vld_cnt;
        codec_strobe = 1'b1;
        tick();
        codec_strobe = 1'b0;
        note_step = 20'h00800;
        tick();
        codec_strobe = 1'b1;
        sample_ready = 1'b1;
        sample_in = 16'h7777;
        sb.push_back(16'h7777);
        tick();
        codec_strobe = 1'b0;
        sample_ready = 1'b0;
        chk("ovr_flag", {31'd0, overrun_err}, 1);
        chk("ovr_step", {12'd0, step_size}, 32'h400);
        chk("ovr_sample", {16'd0, sample_out}, 32'h7777);
        repeat (4) tick();
        chk("ovr_gen_cnt", gen_cnt - g0, 1);
        chk("ovr_vld_cnt", vld_cnt - v0, 1);

        // 6. reset mid-WAIT
        v0 = vld_cnt;
        codec_strobe = 1'b1;
        tick();
        codec_strobe = 1'b0;
        tick();
        sample_ready = 1'b1;
        sample_in = 16'h9999;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_gen", {31'd0, generate_next}, 0);
        chk("mid_rst_step", {12'd0, step_size}, 0);
        chk("mid_rst_sample", {16'd0, sample_out}, 0);
        chk("mid_rst_flags", {30'd0, timeout_err, overrun_err}, 0);
        tick();
        sample_ready = 1'b0;
        reset = 1'b0;
        repeat (5) tick();
        chk("mid_rst_vld_cnt", vld_cnt - v0, 0);
        chk("mid_rst_flags_after", {30'd0, timeout_err, overrun_err}, 0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
